// File: rtl/parity.sv
// parity: serial parity tracker, a two-state EVEN/ODD Moore FSM with output y = state ^ ODD_SENSE.
// Defining PARITY_FRAME_EN adds per-frame parity (frame_done, frame_parity) every FRAME_LEN bits.
module parity #(
   parameter bit ODD_SENSE = 1'b0,
   parameter int FRAME_LEN = 8
) (
   input  logic x,
   input  logic clk,
   output logic y,
   input  logic rst
`ifdef PARITY_FRAME_EN
   ,
   output logic frame_done,
   output logic frame_parity
`endif
);
   typedef enum logic {EVEN = 1'b0, ODD = 1'b1} state_t;
   // the initialiser gives defined parity even if rst is never asserted
   state_t state = EVEN;
   assign y = state ^ ODD_SENSE;
`ifdef PARITY_FRAME_EN
   localparam int CW = $clog2(FRAME_LEN);
   logic [CW-1:0] cnt = '0;
   logic last;
   assign last = cnt == CW'(FRAME_LEN - 1);
   always_ff @(posedge clk)
      if (rst) begin
         state        <= EVEN;
         cnt          <= '0;
         frame_done   <= 1'b0;
         frame_parity <= 1'b0;
      end else begin
         frame_done <= last;
         if (last) begin
            // the frame's closing bit folds into the latched parity, then a new frame starts
            frame_parity <= state ^ x ^ ODD_SENSE;
            state        <= EVEN;
            cnt          <= '0;
         end else begin
            state <= x ? state_t'(~state) : state;
            cnt   <= cnt + 1'b1;
         end
      end
`else
   always_ff @(posedge clk)
      if (rst) state <= EVEN;
      else if (x) state <= state == EVEN ? ODD : EVEN;
`endif
endmodule

// File: tb/tb_parity.sv
// tb_parity: table-driven scoreboard bench for parity (ODD_SENSE 0 and 1; frame checks when PARITY_FRAME_EN is defined).
module tb_parity;
   logic clk = 1'b0, rst = 1'b0, x = 1'b0;
   logic y0, y1, y2;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;

`ifdef PARITY_FRAME_EN
   logic fd0, fp0, fd1, fp1, fd2, fp2;
   parity #(.ODD_SENSE(1'b0), .FRAME_LEN(255)) u0 (.x(x), .clk(clk), .y(y0), .rst(rst), .frame_done(fd0), .frame_parity(fp0));
   parity #(.ODD_SENSE(1'b1), .FRAME_LEN(255)) u1 (.x(x), .clk(clk), .y(y1), .rst(rst), .frame_done(fd1), .frame_parity(fp1));
   parity #(.ODD_SENSE(1'b0), .FRAME_LEN(4))   u2 (.x(x), .clk(clk), .y(y2), .rst(rst), .frame_done(fd2), .frame_parity(fp2));
`else
   parity #(.ODD_SENSE(1'b0), .FRAME_LEN(255)) u0 (.x(x), .clk(clk), .y(y0), .rst(rst));
   parity #(.ODD_SENSE(1'b1), .FRAME_LEN(255)) u1 (.x(x), .clk(clk), .y(y1), .rst(rst));
   assign y2 = 1'b0;
`endif

   // y is the expected output of the ODD_SENSE=0 running tracker; f marks the FRAME_LEN=4 frame sequence
   typedef struct {
      bit rst, x, y, f, y2, fd, fp;
   } rec_t;
   rec_t vec[$];
   rec_t sb[$];

   function automatic rec_t v(bit r, bit xi, bit ey, bit f = 0, bit ey2 = 0, bit efd = 0, bit efp = 0);
      rec_t t;
      t.rst = r; t.x = xi; t.y = ey; t.f = f; t.y2 = ey2; t.fd = efd; t.fp = efp;
      return t;
   endfunction

   task automatic chk(string name, int idx, logic act, logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
      end
   endtask

   task automatic apply(rec_t t, int idx);
      rec_t e;
      @(negedge clk);
      rst = t.rst;
      x   = t.x;
      sb.push_back(t);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("y_sense0", idx, y0, e.y);
      chk("y_sense1", idx, y1, ~e.y);
`ifdef PARITY_FRAME_EN
      if (e.f) begin
         chk("frame_y", idx, y2, e.y2);
         chk("frame_done", idx, fd2, e.fd);
         chk("frame_parity", idx, fp2, e.fp);
      end
`endif
   endtask

   initial begin
      bit s[12] = '{0,1,1,1,0,1,1,0,0,1,1,0};
      bit e[12] = '{0,1,0,1,1,0,1,1,1,0,1,1};
      bit fx[8] = '{1,1,1,0,1,0,0,0};
      bit fy[8] = '{1,0,1,0,1,1,1,0};
      bit fdv[8] = '{0,0,0,1,0,0,0,1};
      bit fpv[8] = '{0,0,0,1,1,1,1,1};
      bit ry[8] = '{1,0,1,1,0,0,0,0};
      #1;
      chk("powerup_y_sense0", -1, y0, 1'b0);
      chk("powerup_y_sense1", -1, y1, 1'b1);
      for (int i = 0; i < 12; i++) vec.push_back(v(0, s[i], e[i]));
      vec.push_back(v(1, 1, 0));
      vec.push_back(v(1, 0, 0));
      for (int i = 0; i < 3; i++) vec.push_back(v(0, 0, 0));
      vec.push_back(v(1, 0, 0));
      for (int i = 0; i < 12; i++) vec.push_back(v(0, s[i], e[i]));
      vec.push_back(v(1, 0, 0));
      vec.push_back(v(0, 1, 1));
      vec.push_back(v(0, 1, 0));
      vec.push_back(v(0, 1, 1));
      vec.push_back(v(1, 1, 0));
      vec.push_back(v(0, 1, 1));
      vec.push_back(v(1, 0, 0));
      vec.push_back(v(0, 1, 1));
      vec.push_back(v(0, 0, 1));
      vec.push_back(v(0, 1, 0));
      vec.push_back(v(1, 1, 0, 1, 0, 0, 0));
      for (int i = 0; i < 8; i++) vec.push_back(v(0, fx[i], ry[i], 1, fy[i], fdv[i], fpv[i]));
      vec.push_back(v(0, 0, 0, 1, 0, 0, 1));
      vec.push_back(v(0, 1, 1, 1, 1, 0, 1));
      vec.push_back(v(1, 0, 0, 1, 0, 0, 0));
      foreach (vec[i]) apply(vec[i], i);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
